writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Parametrised successor to the single-port writeback stage.
- Registers an N-lane MEM→WB bundle behind a valid/ready handshake.
- Extracts and extends load data by size and byte offset; writes up to LANES register-file ports per cycle.
- Provides forwarding, commit trace and a retired-instruction counter; sits between memory stage and regfile.

Parameters:
XLEN, 64, datapath width (32 or 64)
LANES, 2, instructions per bundle (1..4)
REG_W, 5, register index width
CNT_W, 64, retired counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  bundle valid from memory stage
in_ready  output  1  unit can accept bundle
in_lane_valid  input  LANES  per-lane instruction present
in_pc  input  LANES x XLEN  per-lane PC
in_dst  input  LANES x REG_W  destination register
in_wen  input  LANES  lane writes a register
in_is_load  input  LANES  lane is a load
in_ld_size  input  LANES x 2  0=B,1=H,2=W,3=D
in_ld_unsigned  input  LANES  zero-extend load
in_addr_lo  input  LANES x 3  low address bits
in_result  input  LANES x XLEN  ALU/CSR result
in_rdata  input  LANES x XLEN  raw memory data (aligned dword)
flush  input  1  discard held and incoming bundle
rf_wready  input  1  regfile accepts writes this cycle
rf_wvalid  output  LANES  per-port write enable
rf_wa  output  LANES x REG_W  write address
rf_wd  output  LANES x XLEN  write data
fwd_valid  output  LANES  forwarding entry valid
fwd_dst  output  LANES x REG_W  forwarded register
fwd_data  output  LANES x XLEN  forwarded value
commit_valid  output  LANES  lane retired this cycle
commit_pc  output  LANES x XLEN  retired PC
retired_cnt  output  CNT_W  total retired instructions

Behaviour:
- Reset (reset=0 at posedge): held-valid cleared, all lane registers cleared, retired_cnt=0.
  - All outputs 0 while reset is low, including in_ready.
- Storage: one bundle register (all lanes).
  - in_ready = !held_valid || (rf_wready && !flush), combinational.
- Accept: in_valid && in_ready at posedge loads the bundle.
  - Load data is computed before registering.
  - Latency is 1 cycle from accept to rf_wvalid.
- Load extraction for XLEN=64:
  - offset = in_addr_lo masked to size alignment (B: all 3 bits; H: bits 2:1; W: bit 2; D: 0).
  - Selected field = rdata >> (offset*8), truncated to size, then sign- or zero-extended to XLEN.
  - For XLEN=32, size D is illegal and treated as W; bit 2 is ignored.
  - Non-load lanes use in_result.
- Drain: when held_valid && rf_wready:
  - rf_wvalid[i] = lane_valid[i] && wen[i] && dst[i]!=0.
  - commit_valid[i] = lane_valid[i].
  - held_valid clears unless a new bundle is accepted in the same cycle (back-to-back, full throughput).
- Stall: held_valid && !rf_wready.
  - Outputs rf_wvalid=0 and commit_valid=0; the bundle is held unchanged and in_ready=0.
  - fwd_* remain asserted from the held bundle.
- Intra-bundle same-dst conflict: a younger (higher-index) lane wins.
  - The older lane's rf_wvalid and fwd_valid are suppressed; commit_valid is unaffected.
- x0: never written, never forwarded. fwd_valid = held_valid && rf_wvalid-condition ignoring rf_wready.
- retired_cnt: incremented at each drain by the popcount of lane_valid. Wraps modulo 2^CNT_W.
- flush: at posedge clears held_valid and drops any simultaneous input.
  - Drives rf_wvalid=0 and commit_valid=0 that cycle.
  - flush has priority over drain and accept. retired_cnt is unchanged.
- Reset mid-stall: held bundle is lost; nothing is committed.

Decomposition:
- Shared package: ld_size_t enum (LS_B, LS_H, LS_W, LS_D), a wb_lane_t struct (pc, dst, wen, is_load, size, unsigned, addr_lo, result, rdata), and a DRAIN helper typedef.
- Sub-module load_extract: combinational, one instance per lane. Inputs rdata, addr_lo, size, unsigned; output extended data.
- Top-level holds the register, handshake, conflict masking and counter.

Test Plan:
- Load byte, signed: rdata=0x0000_00F0_0000_0000, addr_lo=4, LB, dst=5 -> next cycle rf_wvalid[0]=1, rf_wa=5, rf_wd=0xFFFF_FFFF_FFFF_FFF0. Same with LBU -> 0xF0.
- Halfword/word offsets: rdata=0x8765_4321_1234_5678, LH addr_lo=6 -> 0xFFFF_FFFF_FFFF_8765. LWU addr_lo=4 -> 0x8765_4321. addr_lo=7 on LH masked to 6.
- Stall: bundle accepted, rf_wready=0 for 3 cycles -> in_ready=0, rf_wvalid=0, fwd_valid held. rf_wready=1 -> single write, retired_cnt +=2.
- Same-dst conflict: lane0 and lane1 both dst=7 with results 0x11 and 0x22 -> only rf_wvalid[1], rf_wd=0x22, commit_valid=2'b11.
- dst=x0 and flush: lane dst=0 with wen -> no write, still committed. flush asserted with in_valid while held -> no commit, retired_cnt unchanged, in_ready=1 next cycle.
- Back-to-back and wrap: 8 continuous bundles with rf_wready=1 -> one drain per cycle. With CNT_W=4 from 14, one 2-lane drain -> retired_cnt=0.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit.
//   ld_size_t  : load access size (byte/half/word/dword)
//   wb_lane_t  : one lane of a MEM->WB bundle, at maximum field widths
//   wb_drain_t : what the held bundle does this cycle
//   lane_count : popcount of up to WB_LANES_MAX lane-valid bits
package writeback_unit_pkg;

  localparam int WB_LANES_MAX = 4;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2,
    LS_D = 2'd3
  } ld_size_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  dst;
    logic        wen;
    logic        is_load;
    ld_size_t    size;
    logic        is_unsigned;
    logic [2:0]  addr_lo;
    logic [63:0] result;
    logic [63:0] rdata;
  } wb_lane_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_DRAIN,
    WB_STALL,
    WB_FLUSH
  } wb_drain_t;

  function automatic logic [2:0] lane_count(input logic [WB_LANES_MAX-1:0] v);
    lane_count = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// MEM->WB bundle handshake plus the regfile write port.
//   master : memory stage / regfile side (drives bundle and rf_wready)
//   slave  : writeback unit (drives in_ready and the rf_w* writes)
interface writeback_unit_if
  import writeback_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int LANES = 2,
  parameter int REG_W = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             in_lane_valid;
  logic [LANES-1:0][XLEN-1:0]   in_pc;
  logic [LANES-1:0][REG_W-1:0]  in_dst;
  logic [LANES-1:0]             in_wen;
  logic [LANES-1:0]             in_is_load;
  ld_size_t [LANES-1:0]         in_ld_size;
  logic [LANES-1:0]             in_ld_unsigned;
  logic [LANES-1:0][2:0]        in_addr_lo;
  logic [LANES-1:0][XLEN-1:0]   in_result;
  logic [LANES-1:0][XLEN-1:0]   in_rdata;
  logic                         rf_wready;
  logic [LANES-1:0]             rf_wvalid;
  logic [LANES-1:0][REG_W-1:0]  rf_wa;
  logic [LANES-1:0][XLEN-1:0]   rf_wd;

  modport master (
    output in_valid, in_lane_valid, in_pc, in_dst, in_wen, in_is_load,
           in_ld_size, in_ld_unsigned, in_addr_lo, in_result, in_rdata, rf_wready,
    input  in_ready, rf_wvalid, rf_wa, rf_wd
  );

  modport slave (
    input  in_valid, in_lane_valid, in_pc, in_dst, in_wen, in_is_load,
           in_ld_size, in_ld_unsigned, in_addr_lo, in_result, in_rdata, rf_wready,
    output in_ready, rf_wvalid, rf_wa, rf_wd
  );
endinterface

// File: rtl/writeback_unit_load_extract.sv
// Per-lane load alignment and extension (combinational).
//   rdata       : aligned memory word as returned by the data port
//   addr_lo     : low address bits of the access
//   size        : access size; D on a 32-bit datapath degrades to W
//   is_unsigned : zero-extend instead of sign-extend
//   data        : extracted, extended load value
module load_extract
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  ld_size_t        size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);
  ld_size_t    eff;
  logic [2:0]  off;
  logic [63:0] rd64, sh, ext;
  logic        sb, sh_b, sw;

  // Work at 64 bits throughout so replication counts stay legal at XLEN=32.
  assign rd64 = 64'(rdata);

  always_comb begin
    eff = size;
    if (XLEN == 32 && size == LS_D) eff = LS_W;
    // Offset is forced to the natural alignment of the access.
    case (eff)
      LS_B:    off = addr_lo;
      LS_H:    off = {addr_lo[2:1], 1'b0};
      LS_W:    off = {addr_lo[2], 2'b00};
      default: off = 3'b000;
    endcase
    if (XLEN == 32) off[2] = 1'b0;
    sh   = rd64 >> {off, 3'b000};
    sb   = sh[7]  & ~is_unsigned;
    sh_b = sh[15] & ~is_unsigned;
    sw   = sh[31] & ~is_unsigned;
    case (eff)
      LS_B:    ext = {{56{sb}},   sh[7:0]};
      LS_H:    ext = {{48{sh_b}}, sh[15:0]};
      LS_W:    ext = {{32{sw}},   sh[31:0]};
      default: ext = sh;
    endcase
    data = ext[XLEN-1:0];
  end
endmodule

// File: rtl/writeback_unit.sv
// Multi-lane writeback stage: one bundle register between memory stage and
// regfile, with load extraction, same-dst masking, forwarding, commit trace
// and a retired-instruction counter.
//   clk, reset   : clock, synchronous active-low reset
//   bus (slave)  : bundle handshake in, regfile write ports out
//   flush        : drop held and incoming bundle
//   fwd_*        : forwarding view of the held bundle (held during stall)
//   commit_*     : lanes retired this cycle
//   retired_cnt  : running retired-instruction count (wraps)
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int LANES = 2,
  parameter int REG_W = 5,
  parameter int CNT_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  writeback_unit_if.slave              bus,
  input  logic                         flush,
  output logic [LANES-1:0]             fwd_valid,
  output logic [LANES-1:0][REG_W-1:0]  fwd_dst,
  output logic [LANES-1:0][XLEN-1:0]   fwd_data,
  output logic [LANES-1:0]             commit_valid,
  output logic [LANES-1:0][XLEN-1:0]   commit_pc,
  output logic [CNT_W-1:0]             retired_cnt
);
  logic                        held_valid;
  logic [LANES-1:0]            h_lv, h_wen, wr_ok;
  logic [LANES-1:0][REG_W-1:0] h_dst;
  logic [LANES-1:0][XLEN-1:0]  h_pc, h_data, ld_data, wb_data;
  logic [CNT_W-1:0]            cnt;
  wb_drain_t                   act;
  logic                        accept, drain;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    load_extract #(.XLEN(XLEN)) u_ext (
      .rdata       (bus.in_rdata[i]),
      .addr_lo     (bus.in_addr_lo[i]),
      .size        (bus.in_ld_size[i]),
      .is_unsigned (bus.in_ld_unsigned[i]),
      .data        (ld_data[i])
    );
    assign wb_data[i] = bus.in_is_load[i] ? ld_data[i] : bus.in_result[i];
  end

  // A lane writes if it targets a non-zero register and no younger lane in
  // the same bundle writes that register too.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wr_ok[i] = h_lv[i] && h_wen[i] && (h_dst[i] != '0);
      for (int j = i + 1; j < LANES; j++)
        if (h_lv[j] && h_wen[j] && (h_dst[j] == h_dst[i])) wr_ok[i] = 1'b0;
    end
  end

  always_comb begin
    if (flush)                act = WB_FLUSH;
    else if (!held_valid)     act = WB_IDLE;
    else if (bus.rf_wready)   act = WB_DRAIN;
    else                      act = WB_STALL;
  end

  assign drain        = reset && (act == WB_DRAIN);
  assign bus.in_ready = reset && (!held_valid || (bus.rf_wready && !flush));
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Everything is forced low while reset is held, before the first edge clears state.
  assign bus.rf_wvalid = drain ? wr_ok : '0;
  assign commit_valid  = drain ? h_lv  : '0;
  assign fwd_valid     = (reset && held_valid) ? wr_ok : '0;
  assign bus.rf_wa     = reset ? h_dst  : '0;
  assign fwd_dst       = reset ? h_dst  : '0;
  assign bus.rf_wd     = reset ? h_data : '0;
  assign fwd_data      = reset ? h_data : '0;
  assign commit_pc     = reset ? h_pc   : '0;
  assign retired_cnt   = reset ? cnt    : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      held_valid <= 1'b0;
      h_lv       <= '0;
      h_wen      <= '0;
      h_dst      <= '0;
      h_pc       <= '0;
      h_data     <= '0;
      cnt        <= '0;
    end else begin
      if (drain) cnt <= cnt + CNT_W'(lane_count(WB_LANES_MAX'(h_lv)));
      if (flush) held_valid <= 1'b0;
      else if (accept) begin
        held_valid <= 1'b1;
        h_lv       <= bus.in_lane_valid;
        h_wen      <= bus.in_wen;
        h_dst      <= bus.in_dst;
        h_pc       <= bus.in_pc;
        h_data     <= wb_data;
      end else if (drain) held_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int XLEN = 64, LANES = 2, REG_W = 5, CNT_W = 4;

  logic clk = 1'b0;
  logic reset, flush;
  logic [LANES-1:0]            fwd_valid, commit_valid;
  logic [LANES-1:0][REG_W-1:0] fwd_dst;
  logic [LANES-1:0][XLEN-1:0]  fwd_data, commit_pc;
  logic [CNT_W-1:0]            retired_cnt;

  writeback_unit_if #(.XLEN(XLEN), .LANES(LANES), .REG_W(REG_W)) bus ();

  writeback_unit #(.XLEN(XLEN), .LANES(LANES), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       wv, cv;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd, pc;
    logic [3:0]       cnt;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] model_cnt = '0;
  int         checks = 0, errors = 0, drains = 0, d0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic wb_lane_t mk(input logic [63:0] pc, input logic [7:0] dst, input logic wen,
      input logic is_ld, input ld_size_t sz, input logic uns, input logic [2:0] a,
      input logic [63:0] res, input logic [63:0] rd);
    wb_lane_t l;
    l.pc = pc; l.dst = dst; l.wen = wen; l.is_load = is_ld; l.size = sz;
    l.is_unsigned = uns; l.addr_lo = a; l.result = res; l.rdata = rd;
    return l;
  endfunction

  task automatic set_lane(input int i, input logic lv, input wb_lane_t l);
    bus.in_lane_valid[i]  = lv;
    bus.in_pc[i]          = l.pc;
    bus.in_dst[i]         = l.dst[4:0];
    bus.in_wen[i]         = l.wen;
    bus.in_is_load[i]     = l.is_load;
    bus.in_ld_size[i]     = l.size;
    bus.in_ld_unsigned[i] = l.is_unsigned;
    bus.in_addr_lo[i]     = l.addr_lo;
    bus.in_result[i]      = l.result;
    bus.in_rdata[i]       = l.rdata;
  endtask

  task automatic push(input logic [1:0] wv, input logic [1:0] cv,
      input logic [4:0] a0, input logic [63:0] d0, input logic [4:0] a1, input logic [63:0] d1,
      input logic [63:0] p0, input logic [63:0] p1);
    exp_t e;
    e.wv = wv; e.cv = cv;
    e.wa[0] = a0; e.wd[0] = d0; e.wa[1] = a1; e.wd[1] = d1;
    e.pc[0] = p0; e.pc[1] = p1;
    e.cnt = model_cnt;
    model_cnt = model_cnt + 4'(cv[0]) + 4'(cv[1]);
    q.push_back(e);
  endtask

  // Present the bundle for one rising edge; returns just after that edge.
  task automatic issue();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every committing cycle consumes one expected bundle.
  always @(negedge clk) begin
    if (reset === 1'b1 && commit_valid !== '0) begin
      drains++;
      if (q.size() == 0) chk("unexpected_commit", 64'(commit_valid), 64'd0);
      else begin
        mon_e = q.pop_front();
        chk("commit_valid", 64'(commit_valid), 64'(mon_e.cv));
        chk("rf_wvalid", 64'(bus.rf_wvalid), 64'(mon_e.wv));
        for (int i = 0; i < LANES; i++) begin
          if (mon_e.wv[i]) begin
            chk("rf_wa", 64'(bus.rf_wa[i]), 64'(mon_e.wa[i]));
            chk("rf_wd", bus.rf_wd[i], mon_e.wd[i]);
          end
          if (mon_e.cv[i]) chk("commit_pc", commit_pc[i], mon_e.pc[i]);
        end
        chk("retired_cnt_at_drain", 64'(retired_cnt), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  localparam logic [63:0] RD1 = 64'h0000_00F0_0000_0000;
  localparam logic [63:0] RD2 = 64'h8765_4321_1234_5678;

  initial begin
    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b1; bus.rf_wready = 1'b1;
    set_lane(0, 1'b1, mk(64'h10, 8'd1, 1'b1, 1'b0, LS_D, 1'b0, 3'd0, 64'h1, 64'h0));
    set_lane(1, 1'b1, mk(64'h14, 8'd2, 1'b1, 1'b0, LS_D, 1'b0, 3'd0, 64'h2, 64'h0));

    // Reset state, with a bundle offered that must be ignored.
    @(negedge clk);
    chk("rst_in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_rf_wvalid", 64'(bus.rf_wvalid), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_retired_cnt", 64'(retired_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);
    chk("no_commit_after_reset", 64'(commit_valid), 64'd0);
    step();

    // LB / LBU at offset 4.
    set_lane(0, 1'b1, mk(64'h100, 8'd5, 1'b1, 1'b1, LS_B, 1'b0, 3'd4, 64'h0, RD1));
    set_lane(1, 1'b1, mk(64'h104, 8'd6, 1'b1, 1'b1, LS_B, 1'b1, 3'd4, 64'h0, RD1));
    push(2'b11, 2'b11, 5'd5, 64'hFFFF_FFFF_FFFF_FFF0, 5'd6, 64'hF0, 64'h100, 64'h104);
    issue(); step();

    // LH @6 signed, LWU @4.
    set_lane(0, 1'b1, mk(64'h108, 8'd8, 1'b1, 1'b1, LS_H, 1'b0, 3'd6, 64'h0, RD2));
    set_lane(1, 1'b1, mk(64'h10C, 8'd9, 1'b1, 1'b1, LS_W, 1'b1, 3'd4, 64'h0, RD2));
    push(2'b11, 2'b11, 5'd8, 64'hFFFF_FFFF_FFFF_8765, 5'd9, 64'h8765_4321, 64'h108, 64'h10C);
    issue(); step();

    // LH @7 masked to 6, LW @4 signed.
    set_lane(0, 1'b1, mk(64'h110, 8'd10, 1'b1, 1'b1, LS_H, 1'b0, 3'd7, 64'h0, RD2));
    set_lane(1, 1'b1, mk(64'h114, 8'd11, 1'b1, 1'b1, LS_W, 1'b0, 3'd4, 64'h0, RD2));
    push(2'b11, 2'b11, 5'd10, 64'hFFFF_FFFF_FFFF_8765, 5'd11, 64'hFFFF_FFFF_8765_4321, 64'h110, 64'h114);
    issue(); step();

    // LD @5 ignores offset, LBU @1.
    set_lane(0, 1'b1, mk(64'h118, 8'd12, 1'b1, 1'b1, LS_D, 1'b0, 3'd5, 64'h0, RD2));
    set_lane(1, 1'b1, mk(64'h11C, 8'd13, 1'b1, 1'b1, LS_B, 1'b1, 3'd1, 64'h0, RD2));
    push(2'b11, 2'b11, 5'd12, RD2, 5'd13, 64'h56, 64'h118, 64'h11C);
    issue(); step();

    // Non-load uses result; LHU @2.
    set_lane(0, 1'b1, mk(64'h120, 8'd14, 1'b1, 1'b0, LS_B, 1'b0, 3'd3, 64'hDEAD, RD2));
    set_lane(1, 1'b1, mk(64'h124, 8'd15, 1'b1, 1'b1, LS_H, 1'b1, 3'd2, 64'h0, RD2));
    push(2'b11, 2'b11, 5'd14, 64'hDEAD, 5'd15, 64'h1234, 64'h120, 64'h124);
    issue(); step();

    // Stall for 3 cycles, then a single drain.
    bus.rf_wready = 1'b0;
    set_lane(0, 1'b1, mk(64'h200, 8'd3, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'hA, 64'h0));
    set_lane(1, 1'b1, mk(64'h204, 8'd4, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'hB, 64'h0));
    push(2'b11, 2'b11, 5'd3, 64'hA, 5'd4, 64'hB, 64'h200, 64'h204);
    issue();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_rf_wvalid", 64'(bus.rf_wvalid), 64'd0);
      chk("stall_fwd_valid", 64'(fwd_valid), 64'd3);
      step();
    end
    chk("stall_fwd_dst0", 64'(fwd_dst[0]), 64'd3);
    chk("stall_fwd_data1", fwd_data[1], 64'hB);
    bus.rf_wready = 1'b1;
    step();
    chk("stall_retired_cnt", 64'(retired_cnt), 64'd12);

    // Same-dst conflict: younger lane wins.
    set_lane(0, 1'b1, mk(64'h300, 8'd7, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h11, 64'h0));
    set_lane(1, 1'b1, mk(64'h304, 8'd7, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h22, 64'h0));
    push(2'b10, 2'b11, 5'd0, 64'h0, 5'd7, 64'h22, 64'h300, 64'h304);
    issue();
    @(negedge clk);
    chk("conflict_fwd_valid", 64'(fwd_valid), 64'd2);
    step();

    // x0 destination and a non-writing lane still commit.
    set_lane(0, 1'b1, mk(64'h400, 8'd0, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h55, 64'h0));
    set_lane(1, 1'b1, mk(64'h404, 8'd9, 1'b0, 1'b0, LS_B, 1'b0, 3'd0, 64'h66, 64'h0));
    push(2'b00, 2'b11, 5'd0, 64'h0, 5'd0, 64'h0, 64'h400, 64'h404);
    issue();
    @(negedge clk);
    chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);
    step();

    // Flush while held, with a new bundle offered and the regfile ready.
    bus.rf_wready = 1'b0;
    set_lane(0, 1'b1, mk(64'h500, 8'd20, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h77, 64'h0));
    set_lane(1, 1'b1, mk(64'h504, 8'd21, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h78, 64'h0));
    issue();
    set_lane(0, 1'b1, mk(64'h508, 8'd22, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h79, 64'h0));
    bus.in_valid = 1'b1; flush = 1'b1; bus.rf_wready = 1'b1;
    @(negedge clk);
    chk("flush_commit", 64'(commit_valid), 64'd0);
    chk("flush_rf_wvalid", 64'(bus.rf_wvalid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_flush_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("post_flush_retired_cnt", 64'(retired_cnt), 64'(model_cnt));
    step();

    // Eight back-to-back bundles; counter passes 14 -> 0 on the last one.
    d0 = drains;
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 1'b1, mk(64'h4000 + 64'(k * 8), 8'(2 * k + 1), 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h100 + 64'(k), 64'h0));
      set_lane(1, 1'b1, mk(64'h4004 + 64'(k * 8), 8'(2 * k + 2), 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h200 + 64'(k), 64'h0));
      push(2'b11, 2'b11, 5'(2 * k + 1), 64'h100 + 64'(k), 5'(2 * k + 2), 64'h200 + 64'(k),
           64'h4000 + 64'(k * 8), 64'h4004 + 64'(k * 8));
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b_drain_count", 64'(drains - d0), 64'd8);
    chk("wrap_retired_cnt", 64'(retired_cnt), 64'd0);

    // Reset while stalled: the held bundle is lost.
    bus.rf_wready = 1'b0;
    set_lane(0, 1'b1, mk(64'h600, 8'd5, 1'b1, 1'b0, LS_B, 1'b0, 3'd0, 64'h9, 64'h0));
    issue();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_stall_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    reset = 1'b1; bus.rf_wready = 1'b1;
    @(negedge clk);
    chk("rst_stall_commit", 64'(commit_valid), 64'd0);
    chk("rst_stall_held", 64'(fwd_valid), 64'd0);
    chk("rst_stall_retired_cnt", 64'(retired_cnt), 64'd0);
    step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
